uart_tx: RTL

Asynchronous serial transmitter, the transmit counterpart of the team's UART receive path: converts parallel bytes into 8N1 frames (optionally 8E1) on `uart_txd`. It holds a one-entry buffer in front of the shift register so the upstream logic can queue the next byte while the current frame is on the line. Back-to-back bytes produce contiguous frames with no idle gap.

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-entry holding buffer for gap-free back-to-back frames.
// Define UART_TX_PARITY_EN to build the 8E1 variant (even parity bit between data and stop).
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_end    = (timer_q == TMAX);
    timer_d    = bit_end ? '0 : timer_q + TW'(1);

    // Accept and load are mutually exclusive: one needs the buffer empty, the other full.
    if (tx_send && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (buf_full_q) begin
          shift_d    = buf_q;
          buf_full_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered line lines up with the state register.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = ^shift_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (timer_d == TMAX);
  end

  assign tx_ready = ~buf_full_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign uart_txd = txd_q;

endmodule
